// File: rtl/rtc_multi_pkg.sv
// Shared register-map offsets and bit positions for the multi-alarm RTC.
package rtc_multi_pkg;

   localparam logic [11:0] OFF_DR          = 12'h000;
   localparam logic [11:0] OFF_LR          = 12'h004;
   localparam logic [11:0] OFF_CR          = 12'h008;
   localparam logic [11:0] OFF_PRESC       = 12'h00C;
   localparam logic [11:0] OFF_RIS         = 12'h010;
   localparam logic [11:0] OFF_MIS         = 12'h014;
   localparam logic [11:0] OFF_IMSC        = 12'h018;
   localparam logic [11:0] OFF_ICR         = 12'h01C;
   localparam logic [11:0] OFF_MR_BASE     = 12'h040;
   localparam logic [11:0] OFF_PERIOD_BASE = 12'h060;
   localparam logic [11:0] OFF_MCTRL_BASE  = 12'h080;

   // Each per-channel bank spans 8 words; the low 5 address bits pick the channel.
   localparam logic [11:0] CH_BANK_MASK    = 12'hFE0;

   localparam int unsigned MCTRL_MEN_BIT   = 0;
   localparam int unsigned MCTRL_PER_BIT   = 1;
   localparam int unsigned CR_EN_BIT       = 0;

   function automatic logic in_bank(input logic [11:0] addr, input logic [11:0] base);
      return (addr & CH_BANK_MASK) == base;
   endfunction

endpackage

// File: rtl/rtc_match_chan.sv
// One match channel: MR/PERIOD/MCTRL storage, compare on tick, periodic re-arm or one-shot disarm.
module rtc_match_chan
   import rtc_multi_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             tick_i,
   input  logic [CNT_W-1:0] cnt_next_i,
   input  logic [CNT_W-1:0] wdata_i,
   input  logic [1:0]       ctrl_i,
   input  logic             mr_we_i,
   input  logic             per_we_i,
   input  logic             ctrl_we_i,
   output logic [CNT_W-1:0] mr_o,
   output logic [CNT_W-1:0] per_o,
   output logic             men_o,
   output logic             periodic_o,
   output logic             hit_o
);

   logic [CNT_W-1:0] mr_q, mr_d, per_q, per_d;
   logic             men_q, men_d, periodic_q, periodic_d;

   assign hit_o = tick_i & men_q & (cnt_next_i == mr_q);

   // Hardware updates first, so a same-edge APB write overrides them.
   always_comb begin
      mr_d       = mr_q;
      per_d      = per_q;
      men_d      = men_q;
      periodic_d = periodic_q;
      if (hit_o && periodic_q)  mr_d  = mr_q + per_q;
      if (hit_o && !periodic_q) men_d = 1'b0;
      if (mr_we_i)  mr_d  = wdata_i;
      if (per_we_i) per_d = wdata_i;
      if (ctrl_we_i) begin
         men_d      = ctrl_i[MCTRL_MEN_BIT];
         periodic_d = ctrl_i[MCTRL_PER_BIT];
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mr_q       <= '0;
         per_q      <= '0;
         men_q      <= 1'b0;
         periodic_q <= 1'b0;
      end else begin
         mr_q       <= mr_d;
         per_q      <= per_d;
         men_q      <= men_d;
         periodic_q <= periodic_d;
      end
   end

   assign mr_o       = mr_q;
   assign per_o      = per_q;
   assign men_o      = men_q;
   assign periodic_o = periodic_q;

endmodule

// File: rtl/rtc_multi_alarm.sv
// APB real-time counter: prescaler, wrapping counter, N match channels, masked level interrupts.
module rtc_multi_alarm
   import rtc_multi_pkg::*;
#(
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned N_MATCH   = 4,
   parameter int unsigned PRESC_W   = 16,
   parameter int unsigned PRESC_RST = 0
) (
   input  logic               PCLK,
   input  logic               PRESET,
   input  logic               PSEL,
   input  logic               PENABLE,
   input  logic               PWRITE,
   input  logic [11:2]        PADDR,
   input  logic [31:0]        PWDATA,
   output logic [31:0]        PRDATA,
   output logic               RTCINTR,
   output logic [N_MATCH-1:0] RTCINTR_CH,
   output logic               RTCTICK
);

   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [PRESC_W-1:0] pcnt_q, pcnt_d, presc_q, presc_d;
   logic               en_q, en_d;
   logic [N_MATCH:0]   ris_q, ris_d, imsc_q, imsc_d, mis;

   logic [11:0] addr;
   logic [2:0]  chan;
   logic        wr_en, wr_lr, wr_cr, wr_presc, wr_imsc, wr_icr;
   logic        mr_sel, per_sel, ctrl_sel;
   logic        tick, tick_eff, ovf;

   logic [CNT_W-1:0]   mr_a  [N_MATCH];
   logic [CNT_W-1:0]   per_a [N_MATCH];
   logic [N_MATCH-1:0] men_a, periodic_a, hit;

   assign addr     = {PADDR, 2'b00};
   assign chan     = addr[4:2];
   assign wr_en    = PSEL & PENABLE & PWRITE;
   assign wr_lr    = wr_en & (addr == OFF_LR);
   assign wr_cr    = wr_en & (addr == OFF_CR);
   assign wr_presc = wr_en & (addr == OFF_PRESC);
   assign wr_imsc  = wr_en & (addr == OFF_IMSC);
   assign wr_icr   = wr_en & (addr == OFF_ICR);
   assign mr_sel   = in_bank(addr, OFF_MR_BASE);
   assign per_sel  = in_bank(addr, OFF_PERIOD_BASE);
   assign ctrl_sel = in_bank(addr, OFF_MCTRL_BASE);

   // A load in the same cycle swallows the tick: no increment, match or overflow.
   assign tick     = en_q & (pcnt_q == '0);
   assign tick_eff = tick & ~wr_lr;
   assign cnt_inc  = cnt_q + 1'b1;
   assign ovf      = tick_eff & (cnt_q == '1);

   for (genvar g = 0; g < N_MATCH; g++) begin : g_ch
      rtc_match_chan #(.CNT_W(CNT_W)) u_chan (
         .clk_i      (PCLK),
         .rst_i      (PRESET),
         .tick_i     (tick_eff),
         .cnt_next_i (cnt_inc),
         .wdata_i    (PWDATA[CNT_W-1:0]),
         .ctrl_i     ({PWDATA[MCTRL_PER_BIT], PWDATA[MCTRL_MEN_BIT]}),
         .mr_we_i    (wr_en & mr_sel & (chan == 3'(g))),
         .per_we_i   (wr_en & per_sel & (chan == 3'(g))),
         .ctrl_we_i  (wr_en & ctrl_sel & (chan == 3'(g))),
         .mr_o       (mr_a[g]),
         .per_o      (per_a[g]),
         .men_o      (men_a[g]),
         .periodic_o (periodic_a[g]),
         .hit_o      (hit[g])
      );
   end

   always_comb begin
      cnt_d   = cnt_q;
      pcnt_d  = pcnt_q;
      presc_d = presc_q;
      en_d    = en_q;
      imsc_d  = imsc_q;
      ris_d   = ris_q;
      if (en_q) pcnt_d = (pcnt_q == '0) ? presc_q : pcnt_q - 1'b1;
      if (wr_cr) begin
         en_d = PWDATA[CR_EN_BIT];
         if (PWDATA[CR_EN_BIT] && !en_q) pcnt_d = presc_q;
      end
      if (wr_presc) begin
         presc_d = PWDATA[PRESC_W-1:0];
         pcnt_d  = PWDATA[PRESC_W-1:0];
      end
      if (tick_eff) cnt_d = cnt_inc;
      if (wr_lr) begin
         cnt_d  = PWDATA[CNT_W-1:0];
         pcnt_d = presc_q;
      end
      if (wr_imsc) imsc_d = PWDATA[N_MATCH:0];
      // Clear is applied before set so a coincident hardware event survives.
      if (wr_icr) ris_d = ris_q & ~PWDATA[N_MATCH:0];
      ris_d = ris_d | {ovf, hit};
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         cnt_q   <= '0;
         pcnt_q  <= PRESC_W'(PRESC_RST);
         presc_q <= PRESC_W'(PRESC_RST);
         en_q    <= 1'b0;
         imsc_q  <= '0;
         ris_q   <= '0;
      end else begin
         cnt_q   <= cnt_d;
         pcnt_q  <= pcnt_d;
         presc_q <= presc_d;
         en_q    <= en_d;
         imsc_q  <= imsc_d;
         ris_q   <= ris_d;
      end
   end

   always_comb begin
      PRDATA = '0;
      case (addr)
         OFF_DR:    PRDATA[CNT_W-1:0]   = cnt_q;
         OFF_CR:    PRDATA[CR_EN_BIT]   = en_q;
         OFF_PRESC: PRDATA[PRESC_W-1:0] = presc_q;
         OFF_RIS:   PRDATA[N_MATCH:0]   = ris_q;
         OFF_MIS:   PRDATA[N_MATCH:0]   = mis;
         OFF_IMSC:  PRDATA[N_MATCH:0]   = imsc_q;
         default:   ;
      endcase
      for (int unsigned i = 0; i < N_MATCH; i++) begin
         if (chan == 3'(i)) begin
            if (mr_sel)  PRDATA[CNT_W-1:0] = mr_a[i];
            if (per_sel) PRDATA[CNT_W-1:0] = per_a[i];
            if (ctrl_sel) begin
               PRDATA[MCTRL_MEN_BIT] = men_a[i];
               PRDATA[MCTRL_PER_BIT] = periodic_a[i];
            end
         end
      end
      if (!(PSEL && !PWRITE)) PRDATA = '0;
   end

   assign mis        = ris_q & imsc_q;
   assign RTCINTR_CH = mis[N_MATCH-1:0];
   assign RTCINTR    = |mis;
   assign RTCTICK    = tick;

endmodule

// File: tb/tb_rtc_multi_alarm.sv
// Directed self-checking bench for rtc_multi_alarm (CNT_W=8, N_MATCH=4, PRESC_RST=5).
module tb_rtc_multi_alarm;

   localparam logic [11:0] A_DR = 12'h000, A_LR = 12'h004, A_CR = 12'h008, A_PRESC = 12'h00C;
   localparam logic [11:0] A_RIS = 12'h010, A_MIS = 12'h014, A_IMSC = 12'h018, A_ICR = 12'h01C;
   localparam logic [11:0] A_MR0 = 12'h040, A_PER0 = 12'h060, A_MCTRL0 = 12'h080;

   logic        PCLK = 1'b0, PRESET = 1'b1, PSEL = 1'b0, PENABLE = 1'b0, PWRITE = 1'b0;
   logic [11:2] PADDR = '0;
   logic [31:0] PWDATA = '0, PRDATA;
   logic        RTCINTR, RTCTICK;
   logic [3:0]  RTCINTR_CH;

   int n_cmp = 0;
   int n_bad = 0;

   rtc_multi_alarm #(.CNT_W(8), .N_MATCH(4), .PRESC_W(16), .PRESC_RST(5)) dut (
      .PCLK(PCLK), .PRESET(PRESET), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
      .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .RTCINTR(RTCINTR),
      .RTCINTR_CH(RTCINTR_CH), .RTCTICK(RTCTICK)
   );

   always #5 PCLK = ~PCLK;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Called just after a negedge; the write lands on the second following posedge.
   task automatic wr(input logic [11:0] a, input logic [31:0] d);
      PSEL = 1'b1; PWRITE = 1'b1; PENABLE = 1'b0; PADDR = a[11:2]; PWDATA = d;
      @(negedge PCLK);
      PENABLE = 1'b1;
      @(negedge PCLK);
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic rd(input logic [11:0] a, output logic [31:0] d);
      PSEL = 1'b1; PWRITE = 1'b0; PENABLE = 1'b1; PADDR = a[11:2];
      #1 d = PRDATA;
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   task automatic do_reset();
      PRESET = 1'b1;
      @(negedge PCLK);
      PRESET = 1'b0;
   endtask

   typedef struct {
      logic        w;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp;
      string       name;
   } vec_t;

   localparam int NV = 17;
   vec_t vecs [NV];

   initial begin
      logic [31:0] d, d2;
      logic        ok;

      vecs[0]  = '{1'b0, A_DR,         32'h0,       32'h0,    "rst_dr"};
      vecs[1]  = '{1'b0, A_CR,         32'h0,       32'h0,    "rst_cr"};
      vecs[2]  = '{1'b0, A_PRESC,      32'h0,       32'h5,    "rst_presc"};
      vecs[3]  = '{1'b0, A_RIS,        32'h0,       32'h0,    "rst_ris"};
      vecs[4]  = '{1'b0, A_IMSC,       32'h0,       32'h0,    "rst_imsc"};
      vecs[5]  = '{1'b1, A_MR0,        32'h1AB,     32'hAB,   "mr0_trunc"};
      vecs[6]  = '{1'b1, A_PER0+12'hC, 32'h177,     32'h77,   "per3"};
      vecs[7]  = '{1'b1, A_MCTRL0+12'h8, 32'hFF,    32'h3,    "mctrl2"};
      vecs[8]  = '{1'b1, A_MR0+12'h10, 32'h55,      32'h0,    "mr4_unmapped"};
      vecs[9]  = '{1'b1, 12'h0F0,      32'hDEAD,    32'h0,    "off_0f0"};
      vecs[10] = '{1'b1, A_IMSC,       32'hFF,      32'h1F,   "imsc_width"};
      vecs[11] = '{1'b1, A_PRESC,      32'h12345,   32'h2345, "presc_width"};
      vecs[12] = '{1'b1, A_LR,         32'h142,     32'h0,    "lr_wo"};
      vecs[13] = '{1'b0, A_DR,         32'h0,       32'h42,   "dr_loaded"};
      vecs[14] = '{1'b0, A_MIS,        32'h0,       32'h0,    "mis_zero"};
      vecs[15] = '{1'b1, A_ICR,        32'h1F,      32'h0,    "icr_wo"};
      vecs[16] = '{1'b1, A_CR,         32'hFE,      32'h0,    "cr_en_only"};

      @(negedge PCLK);
      chk("rst_prdata", PRDATA, 32'h0);
      chk("rst_intr", {31'b0, RTCINTR}, 32'h0);
      chk("rst_intr_ch", {28'b0, RTCINTR_CH}, 32'h0);
      chk("rst_tick", {31'b0, RTCTICK}, 32'h0);
      PRESET = 1'b0;
      @(negedge PCLK);

      for (int i = 0; i < NV; i++) begin
         if (vecs[i].w) wr(vecs[i].addr, vecs[i].wdata);
         rd(vecs[i].addr, d);
         chk(vecs[i].name, d, vecs[i].exp);
      end

      // Prescaler: PRESC=3 gives a tick every 4th cycle after enable.
      do_reset();
      wr(A_PRESC, 32'd3);
      wr(A_CR, 32'd1);
      for (int k = 1; k <= 12; k++) begin
         rd(A_DR, d);
         chk($sformatf("presc_tick_c%0d", k), {31'b0, RTCTICK}, {31'b0, (k % 4) == 0});
         if ((k % 4) == 0) chk($sformatf("presc_dr_c%0d", k), d, 32'((k - 1) / 4));
         @(negedge PCLK);
      end
      wr(A_CR, 32'd0);
      repeat (10) @(negedge PCLK);
      rd(A_DR, d);
      chk("presc_frozen_dr", d, 32'd3);
      chk("presc_frozen_tick", {31'b0, RTCTICK}, 32'h0);

      // One-shot on channel 0.
      do_reset();
      wr(A_PRESC, 32'd0);
      wr(A_LR, 32'd10);
      wr(A_MR0, 32'd13);
      wr(A_MCTRL0, 32'd1);
      wr(A_IMSC, 32'd1);
      wr(A_CR, 32'd1);
      for (int k = 1; k <= 4; k++) begin
         rd(A_DR, d);
         chk($sformatf("os_dr_c%0d", k), d, 32'(9 + k));
         chk($sformatf("os_intr_c%0d", k), {31'b0, RTCINTR}, {31'b0, k == 4});
         if (k < 4) @(negedge PCLK);
      end
      chk("os_intr_ch", {28'b0, RTCINTR_CH}, 32'h1);
      rd(A_MCTRL0, d);
      chk("os_men_cleared", d, 32'h0);
      wr(A_ICR, 32'd1);
      chk("os_intr_cleared", {31'b0, RTCINTR}, 32'h0);
      repeat (300) @(negedge PCLK);
      rd(A_RIS, d);
      chk("os_no_retrigger", d, 32'h10);
      chk("os_intr_after_wrap", {31'b0, RTCINTR}, 32'h0);

      // Periodic on channel 1: hits at 5, 10, 15, then MR reads 20.
      do_reset();
      wr(A_PRESC, 32'd0);
      wr(A_MR0 + 12'h4, 32'd5);
      wr(A_PER0 + 12'h4, 32'd5);
      wr(A_MCTRL0 + 12'h4, 32'd3);
      wr(A_CR, 32'd1);
      for (int h = 1; h <= 3; h++) begin
         ok = 1'b0;
         for (int k = 0; k < 40 && !ok; k++) begin
            rd(A_RIS, d);
            if (d[1]) ok = 1'b1;
            else @(negedge PCLK);
         end
         chk($sformatf("per_found_%0d", h), {31'b0, ok}, 32'h1);
         rd(A_DR, d);
         chk($sformatf("per_dr_%0d", h), d, 32'(5 * h));
         if (h == 3) begin
            rd(A_MR0 + 12'h4, d2);
            chk("per_mr_next", d2, 32'd20);
         end
         wr(A_ICR, 32'h2);
      end
      wr(A_CR, 32'd0);

      // Overflow then match just past the wrap.
      do_reset();
      wr(A_PRESC, 32'd0);
      wr(A_LR, 32'hFE);
      wr(A_MR0 + 12'h8, 32'h01);
      wr(A_MCTRL0 + 12'h8, 32'd1);
      wr(A_CR, 32'd1);
      for (int k = 1; k <= 4; k++) begin
         rd(A_DR, d);
         rd(A_RIS, d2);
         chk($sformatf("wrap_dr_c%0d", k), d, (k == 1) ? 32'hFE : (k == 2) ? 32'hFF : (k == 3) ? 32'h00 : 32'h01);
         chk($sformatf("wrap_ris_c%0d", k), d2, (k <= 2) ? 32'h0 : (k == 3) ? 32'h10 : 32'h14);
         @(negedge PCLK);
      end

      // Load coinciding with a tick, and load equal to MR.
      do_reset();
      wr(A_PRESC, 32'd0);
      wr(A_CR, 32'd1);
      wr(A_LR, 32'h80);
      rd(A_DR, d);
      chk("lr_tick_dr", d, 32'h80);
      @(negedge PCLK);
      rd(A_DR, d);
      chk("lr_tick_next", d, 32'h81);
      wr(A_CR, 32'd0);
      wr(A_MR0 + 12'hC, 32'h90);
      wr(A_MCTRL0 + 12'hC, 32'd1);
      wr(A_LR, 32'h90);
      wr(A_CR, 32'd1);
      repeat (3) @(negedge PCLK);
      rd(A_RIS, d);
      chk("lr_eq_mr_no_ris", d, 32'h0);

      // ICR landing on the same edge as a match: set wins.
      do_reset();
      wr(A_PRESC, 32'd0);
      wr(A_MR0, 32'd20);
      wr(A_MCTRL0, 32'd1);
      wr(A_CR, 32'd1);
      repeat (18) @(negedge PCLK);
      rd(A_DR, d);
      chk("icr_conf_align", d, 32'd18);
      wr(A_ICR, 32'd1);
      rd(A_DR, d);
      chk("icr_conf_dr", d, 32'd20);
      rd(A_RIS, d);
      chk("icr_conf_ris", d, 32'h1);

      // Reset mid-operation.
      wr(A_IMSC, 32'h1F);
      wr(A_MR0 + 12'h4, 32'h77);
      repeat (3) @(negedge PCLK);
      do_reset();
      rd(A_DR, d);    chk("mrst_dr", d, 32'h0);
      rd(A_CR, d);    chk("mrst_cr", d, 32'h0);
      rd(A_PRESC, d); chk("mrst_presc", d, 32'h5);
      rd(A_IMSC, d);  chk("mrst_imsc", d, 32'h0);
      rd(A_RIS, d);   chk("mrst_ris", d, 32'h0);
      rd(A_MR0 + 12'h4, d); chk("mrst_mr1", d, 32'h0);
      chk("mrst_intr", {31'b0, RTCINTR}, 32'h0);
      chk("mrst_tick", {31'b0, RTCTICK}, 32'h0);
      @(negedge PCLK);
      wr(A_CR, 32'd1);
      for (int k = 1; k <= 6; k++) begin
         #1 chk($sformatf("rstpresc_tick_c%0d", k), {31'b0, RTCTICK}, {31'b0, k == 6});
         @(negedge PCLK);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
